serial_capture_ctrl: RTL

Controller that sequences a chain of D flip-flops as a serial-to-parallel capture register. It starts on a start request and samples a serial input for exactly WIDTH clock edges. It then presents the assembled word on a parallel output under a valid/ready handshake. It sits between a serial bit source and any parallel consumer, and reports start requests that arrive while it cannot accept them.

---
 rtl/serial_capture_ctrl_if.sv | 43 ++++
 rtl/serial_capture_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serial_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_capture_ctrl_if
//  Description : Bundle of the serial input, parallel output and handshake
//                signals of serial_capture_ctrl.
//                slave  - the capture controller side
//                master - the bit source / parallel consumer side
//  Signals     : start, sin, dout_ready  (source/consumer -> controller)
//                busy, dout, dout_valid, overrun (controller -> consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_capture_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sin;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;

    modport slave (
        input  start,
        input  sin,
        input  dout_ready,
        output busy,
        output dout,
        output dout_valid,
        output overrun
    );

    modport master (
        output start,
        output sin,
        output dout_ready,
        input  busy,
        input  dout,
        input  dout_valid,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/serial_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_capture_ctrl
//  Description : Serial-to-parallel capture controller. A start request
//                samples sin on that edge and on the following WIDTH-1
//                edges. The completed word is then presented on dout under
//                a valid/ready handshake. Start requests that cannot be
//                accepted raise a one-cycle overrun pulse.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - serial_capture_ctrl_if.slave (start, sin,
//                         dout_ready in; busy, dout, dout_valid, overrun out)
//  Parameters  : WIDTH     - word length, 2..32
//                MSB_FIRST - 1: first bit lands in dout[WIDTH-1]
//                            0: first bit lands in dout[0]
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_capture_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    serial_capture_ctrl_if.slave   bus
);

    localparam int               c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dout;
    logic               r_valid;
    logic               r_busy;
    logic               r_overrun;
    logic [WIDTH-1:0]   w_sreg_next;

    // Shift register value after taking in the current sin bit.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_next = {r_sreg[WIDTH-2:0], bus.sin};
        end else begin : g_lsb_first
            assign w_sreg_next = {bus.sin, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sreg    <= '0;
            r_cnt     <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // overrun is a pulse: cleared unless this edge rejects a start.
            r_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sreg  <= w_sreg_next;
                        r_cnt   <= c_one;
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_sreg <= w_sreg_next;
                    r_cnt  <= r_cnt + c_one;
                    if (bus.start) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_cnt == c_last) begin
                        // Final bit: publish the word including this bit.
                        r_dout  <= w_sreg_next;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // dout_valid is always set here, so ready alone
                    // completes the handshake.
                    if (bus.dout_ready) begin
                        r_valid <= 1'b0;
                        if (bus.start) begin
                            // Back-to-back: this edge samples the first bit.
                            r_sreg  <= w_sreg_next;
                            r_cnt   <= c_one;
                            r_state <= S_SHIFT;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (bus.start) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_valid;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire
